// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: tagged BTB + 2-bit BHT direction predictor; gshare BHT indexing when BRANCH_PRED_GSHARE_EN is defined
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  input  logic        lookup_is_branch,
  output logic        predicted_taken,
  output logic [31:0] predicted_address,
  output logic        sel,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        mispredict,
  output logic [31:0] mispredict_count,
  output logic [31:0] branch_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       bht_q    [ENTRIES];
  logic [1:0]       bht_d    [ENTRIES];
  logic             mispredict_q, mispredict_d;
  logic [31:0]      mp_cnt_q, mp_cnt_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [IDX_W-1:0] l_idx, u_idx, l_bidx, u_bidx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [1:0]       u_ctr;
  logic             hit;
  logic             unused_bits;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+2 +: TAG_W];
  assign u_tag = upd_pc[IDX_W+2 +: TAG_W];
  assign unused_bits = ^{lookup_pc[31:IDX_W+TAG_W+2], lookup_pc[1:0], upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

`ifdef BRANCH_PRED_GSHARE_EN
  // Global history is non-speculative: it only shifts in resolved outcomes
  logic [GHR_W-1:0] ghr_q, ghr_d;
  assign ghr_d  = upd_valid ? GHR_W'({ghr_q, upd_taken}) : ghr_q;
  assign l_bidx = l_idx ^ IDX_W'(ghr_q);
  assign u_bidx = u_idx ^ IDX_W'(ghr_q);
  // History register
  always_ff @(posedge clk or negedge rst)
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
`else
  localparam int unused_ghr_w = GHR_W;
  assign l_bidx = l_idx;
  assign u_bidx = u_idx;
`endif

  // Lookup reads the registered tables only, so a same-cycle update is not bypassed
  always_comb begin
    hit               = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    predicted_taken   = lookup_is_branch && hit && bht_q[l_bidx][1];
    sel               = predicted_taken;
    predicted_address = predicted_taken ? target_q[l_idx] : lookup_pc + 32'd4;
  end

  assign u_ctr = bht_q[u_bidx];

  // Table next state: counter saturates at 0/3; only taken branches (re)allocate the BTB entry
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    bht_d    = bht_q;
    if (upd_valid) begin
      bht_d[u_bidx] = upd_taken ? (&u_ctr ? u_ctr : u_ctr + 2'd1) : (|u_ctr ? u_ctr - 2'd1 : u_ctr);
      if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
      end
    end
  end

  // Statistics next state: both counters stick at all-ones
  always_comb begin
    mispredict_d = upd_valid && (upd_taken != upd_pred_taken);
    branch_cnt_d = (upd_valid && branch_cnt_q != '1) ? branch_cnt_q + 32'd1 : branch_cnt_q;
    mp_cnt_d     = (mispredict_d && mp_cnt_q != '1) ? mp_cnt_q + 32'd1 : mp_cnt_q;
  end

  // Table registers; counters reset to weakly not-taken
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        bht_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      bht_q    <= bht_d;
    end

  // Mispredict pulse and statistics registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mispredict_q <= 1'b0;
      mp_cnt_q     <= '0;
      branch_cnt_q <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      mp_cnt_q     <= mp_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end

  assign mispredict       = mispredict_q;
  assign mispredict_count = mp_cnt_q;
  assign branch_count     = branch_cnt_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: model-checked directed test of branch_predictor_btb (gshare part when BRANCH_PRED_GSHARE_EN is defined)
module tb_branch_predictor_btb;
  localparam int N  = 16;
  localparam int IW = $clog2(N);
`ifdef BRANCH_PRED_GSHARE_EN
  localparam int GW = 1;
`else
  localparam int GW = IW;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = 32'h100;
  logic        lookup_is_branch = 1'b1;
  logic        predicted_taken, sel, mispredict;
  logic [31:0] predicted_address, mispredict_count, branch_count;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  int          checks = 0;
  int          errors = 0;

  branch_predictor_btb #(.ENTRIES(N), .TAG_W(8), .GHR_W(GW)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_is_branch(lookup_is_branch),
    .predicted_taken(predicted_taken), .predicted_address(predicted_address), .sel(sel),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .mispredict(mispredict),
    .mispredict_count(mispredict_count), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  bit          m_valid [N];
  int          m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_ghr;
  longint      m_bc, m_mc;
  bit          m_mp;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> (IW + 2)) % 256);
  endfunction

  function automatic int bidx_of(logic [31:0] pc);
`ifdef BRANCH_PRED_GSHARE_EN
    return idx_of(pc) ^ m_ghr;
`else
    return idx_of(pc);
`endif
  endfunction

  function automatic bit m_predict(logic [31:0] pc, bit br);
    int i;
    i = idx_of(pc);
    return br && m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[bidx_of(pc)] >= 2;
  endfunction

  // Reference model: tables as plain arrays, updated from the resolved outcome
  always @(posedge clk or negedge rst) begin
    int b, i;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = '0; m_ctr[k] = 1;
      end
      m_ghr = 0; m_bc = 0; m_mc = 0; m_mp = 0;
    end else begin
      m_mp = 0;
      if (upd_valid) begin
        b = bidx_of(upd_pc);
        i = idx_of(upd_pc);
        m_ctr[b] = upd_taken ? (m_ctr[b] == 3 ? 3 : m_ctr[b] + 1) : (m_ctr[b] == 0 ? 0 : m_ctr[b] - 1);
        if (upd_taken) begin
          m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target;
        end
        m_ghr = ((m_ghr << 1) | int'(upd_taken)) % (1 << GW);
        m_mp = upd_taken != upd_pred_taken;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_mp && m_mc < 64'hFFFF_FFFF) m_mc++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    bit          pt;
    logic [31:0] pa;
    pt = m_predict(lookup_pc, lookup_is_branch);
    pa = pt ? m_tgt[idx_of(lookup_pc)] : lookup_pc + 32'd4;
    checks++;
    if ({predicted_taken, sel, predicted_address, mispredict, branch_count, mispredict_count} !==
        {pt, pt, pa, m_mp, m_bc[31:0], m_mc[31:0]}) begin
      errors++;
      $display("FAIL model t=%0t pc=%h got pt=%b sel=%b pa=%h mp=%b bc=%h mc=%h required pt=%b pa=%h mp=%b bc=%h mc=%h",
               $time, lookup_pc, predicted_taken, sel, predicted_address, mispredict, branch_count,
               mispredict_count, pt, pa, m_mp, m_bc[31:0], m_mc[31:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pred);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_pred_taken = pred;
    @(posedge clk);
    #2 upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input bit br);
    @(posedge clk);
    #2 lookup_pc = pc; lookup_is_branch = br;
    #1;
  endtask

  initial begin
    logic [31:0] base;
    #100000 $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    #1 rst = 1'b0;
    #1 chk("in_reset_sel", {31'd0, sel}, 32'd0);
    chk("in_reset_addr", predicted_address, 32'h104);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_sel", {31'd0, sel}, 32'd0);
    chk("reset_addr", predicted_address, 32'h104);
    chk("reset_bc", branch_count, 32'd0);
    chk("reset_mc", mispredict_count, 32'd0);
`ifndef BRANCH_PRED_GSHARE_EN
    upd(32'h100, 1, 32'h40, 0);
    chk("train1_mp", {31'd0, mispredict}, 32'd1);
    upd(32'h100, 1, 32'h40, 1);
    chk("train2_mp", {31'd0, mispredict}, 32'd0);
    look(32'h100, 1);
    chk("trained_sel", {31'd0, sel}, 32'd1);
    chk("trained_addr", predicted_address, 32'h40);
    upd(32'h100, 0, 32'h0, 1);
    chk("nt_mp_pulse", {31'd0, mispredict}, 32'd1);
    chk("nt_bc", branch_count, 32'd3);
    chk("nt_mc", mispredict_count, 32'd2);
    look(32'h100, 1);
    chk("nt_mp_clear", {31'd0, mispredict}, 32'd0);
    chk("after_nt_sel", {31'd0, sel}, 32'd1);
    look(32'h140, 1);
    chk("alias_sel", {31'd0, sel}, 32'd0);
    chk("alias_addr", predicted_address, 32'h144);
    upd(32'h140, 1, 32'h80, 0);
    look(32'h140, 1);
    chk("replace_addr", predicted_address, 32'h80);
    look(32'h100, 1);
    chk("replaced_old_sel", {31'd0, sel}, 32'd0);
    chk("replaced_old_addr", predicted_address, 32'h104);
    for (int k = 0; k < 5; k++) upd(32'h304, 1, 32'h600, 1);
    upd(32'h304, 0, 32'h0, 0);
    look(32'h304, 1);
    chk("sat_one_nt_sel", {31'd0, sel}, 32'd1);
    chk("sat_one_nt_addr", predicted_address, 32'h600);
    upd(32'h304, 0, 32'h0, 1);
    look(32'h304, 1);
    chk("sat_two_nt_sel", {31'd0, sel}, 32'd0);
    chk("sat_two_nt_addr", predicted_address, 32'h308);
    chk("sat_mc", mispredict_count, 32'd4);
    chk("sat_bc", branch_count, 32'd11);
    lookup_pc = 32'h208; lookup_is_branch = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h208; upd_taken = 1'b1; upd_target = 32'h700; upd_pred_taken = 1'b0;
    #1 chk("same_cycle_sel", {31'd0, sel}, 32'd0);
    @(posedge clk);
    #2 upd_valid = 1'b0;
    #1 chk("next_cycle_sel", {31'd0, sel}, 32'd1);
    chk("next_cycle_addr", predicted_address, 32'h700);
    look(32'h208, 0);
    chk("not_branch_sel", {31'd0, sel}, 32'd0);
    chk("not_branch_addr", predicted_address, 32'h20C);
    look(32'hFFFF_FFFC, 1);
    chk("wrap_addr", predicted_address, 32'h0);
`else
    for (int k = 0; k < 6; k++) upd(32'h100 + 32'(k * 4), k % 3 == 0, 32'h40 + 32'(k * 16), 0);
    look(32'h100, 1);
`endif
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    m_bc = 64'hFFFF_FFFF;
    #1 release dut.branch_cnt_q;
    upd(32'h500, 0, 32'h0, 0);
    chk("bc_saturated", branch_count, 32'hFFFF_FFFF);
    #1 rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h44; upd_pred_taken = 1'b0;
    #1 chk("midreset_bc", branch_count, 32'd0);
    chk("midreset_sel", {31'd0, sel}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1; upd_valid = 1'b0;
    #1 chk("reset_edge_upd_ignored", branch_count, 32'd0);
    lookup_pc = 32'h40C; lookup_is_branch = 1'b1;
    base = '0;
    for (int k = 0; k < 32; k++) begin
      upd(32'h40C, k % 2 == 0, 32'h900, m_predict(32'h40C, 1));
      if (k == 15) base = mispredict_count;
    end
`ifdef BRANCH_PRED_GSHARE_EN
    chk("gshare_alt_mispredicts", mispredict_count - base, 32'd0);
`else
    chk("bimodal_alt_mispredicts", mispredict_count - base, 32'd16);
`endif
    @(posedge clk);
    #3 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
